pacman_mover: RTL and testbench

- Consumes the one-hot direction request from the switch-decode stage.
- Steps Pac-Man one tile per move tick on a maze grid.
- Checks each candidate tile against the maze wall lookup over a req/ack handshake.
- Publishes tile position and facing to the graphics stage and the level logic.
- Supports buffered turning: a requested turn is held until it becomes legal; otherwise Pac-Man keeps his current heading or stops at a wall.

---
 rtl/pacman_pkg.sv | 36 +++
 rtl/move_tick_gen.sv | 34 +++
 rtl/pacman_mover.sv | 173 +++++++++++++++++
 tb/tb_pacman_mover.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man tile mover: direction codes,
// FSM states, default maze geometry and the one-hot request patterns.
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ASK_WANT = 2'd1,
        ST_ASK_CUR  = 2'd2,
        ST_MOVE     = 2'd3
    } state_t;

    localparam int DEF_GRID_W  = 28;
    localparam int DEF_GRID_H  = 31;
    localparam int DEF_START_X = 13;
    localparam int DEF_START_Y = 23;

    localparam logic [3:0] ONEHOT_LEFT  = 4'b1000;
    localparam logic [3:0] ONEHOT_RIGHT = 4'b0100;
    localparam logic [3:0] ONEHOT_UP    = 4'b0010;
    localparam logic [3:0] ONEHOT_DOWN  = 4'b0001;

    // Neighbour tile; oob marks a step off the top or bottom edge.
    typedef struct packed {
        logic       oob;
        logic [4:0] x;
        logic [4:0] y;
    } tile_t;

endpackage

// File: rtl/move_tick_gen.sv
// Move-rate divider: one-cycle tick every TICK_DIV enabled clock cycles;
// the count freezes while gameplay is paused.
module move_tick_gen #(
    parameter int TICK_DIV = 5000000
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_r;

    // Divider count, wrapping after the tick cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_r <= '0;
        end else if (enable) begin
            if (count_r == LAST) begin
                count_r <= '0;
            end else begin
                count_r <= count_r + CW'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign tick = enable && (count_r == LAST);

endmodule

// File: rtl/pacman_mover.sv
// Steps Pac-Man one tile per move tick, consulting the maze wall lookup and
// honouring a buffered turn request before falling back to the current heading.
module pacman_mover import pacman_pkg::*; #(
    parameter int GRID_W   = DEF_GRID_W,
    parameter int GRID_H   = DEF_GRID_H,
    parameter int TICK_DIV = 5000000,
    parameter int START_X  = DEF_START_X,
    parameter int START_Y  = DEF_START_Y
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic [3:0] dir_req,
    output logic       wall_req,
    output logic [4:0] wall_x,
    output logic [4:0] wall_y,
    input  logic       wall_ack,
    input  logic       wall_hit,
    output logic [4:0] pos_x,
    output logic [4:0] pos_y,
    output logic [1:0] facing,
    output logic       moved,
    output logic       overrun
);

    state_t     state_r;
    dir_t       cur_dir_r, want_dir_r, ask_dir_r, facing_r, dec_dir_s;
    logic       dec_valid_s, tick_s;
    logic [4:0] pos_x_r, pos_y_r, target_x_r, target_y_r, wall_x_r, wall_y_r;
    logic       wall_req_r, moved_r, overrun_r;
    tile_t      want_nb_s, cur_nb_s;

    move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .enable (enable),
        .tick   (tick_s)
    );

    // Horizontal moves wrap through the side tunnel; vertical ones stop at the edge.
    function automatic tile_t nb(input logic [4:0] x, input logic [4:0] y, input dir_t d);
        tile_t t;
        t.oob = 1'b0;
        t.x   = x;
        t.y   = y;
        case (d)
            DIR_LEFT:  t.x = (x == 5'd0) ? 5'(GRID_W - 1) : x - 5'd1;
            DIR_RIGHT: t.x = (x == 5'(GRID_W - 1)) ? 5'd0 : x + 5'd1;
            DIR_UP:    if (y == 5'd0) t.oob = 1'b1; else t.y = y - 5'd1;
            DIR_DOWN:  if (y == 5'(GRID_H - 1)) t.oob = 1'b1; else t.y = y + 5'd1;
            default:   t.oob = 1'b1;
        endcase
        return t;
    endfunction

    assign want_nb_s = nb(pos_x_r, pos_y_r, want_dir_r);
    assign cur_nb_s  = nb(pos_x_r, pos_y_r, cur_dir_r);

    // One-hot request decode; anything but a single set bit is not a request.
    always_comb begin
        dec_valid_s = 1'b1;
        dec_dir_s   = DIR_LEFT;
        case (dir_req)
            ONEHOT_LEFT:  dec_dir_s = DIR_LEFT;
            ONEHOT_RIGHT: dec_dir_s = DIR_RIGHT;
            ONEHOT_UP:    dec_dir_s = DIR_UP;
            ONEHOT_DOWN:  dec_dir_s = DIR_DOWN;
            default:      dec_valid_s = 1'b0;
        endcase
    end

    // Buffered turn request, latched regardless of FSM state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            want_dir_r <= DIR_LEFT;
        end else if (dec_valid_s) begin
            want_dir_r <= dec_dir_s;
        end else begin
            want_dir_r <= want_dir_r;
        end
    end

    // Step FSM; the lookup for the wanted tile is issued on the tick edge so a
    // first-cycle ack gives a three-cycle tick-to-move latency.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            pos_x_r    <= 5'(START_X);
            pos_y_r    <= 5'(START_Y);
            cur_dir_r  <= DIR_LEFT;
            ask_dir_r  <= DIR_LEFT;
            facing_r   <= DIR_LEFT;
            target_x_r <= 5'd0;
            target_y_r <= 5'd0;
            wall_req_r <= 1'b0;
            wall_x_r   <= 5'd0;
            wall_y_r   <= 5'd0;
            moved_r    <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            moved_r <= 1'b0;
            if (tick_s && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (tick_s) begin
                        ask_dir_r <= want_dir_r;
                        state_r   <= ST_ASK_WANT;
                        if (!want_nb_s.oob) begin
                            wall_req_r <= 1'b1;
                            wall_x_r   <= want_nb_s.x;
                            wall_y_r   <= want_nb_s.y;
                        end
                    end
                end
                ST_ASK_WANT: begin
                    if (!wall_req_r) begin
                        state_r <= ST_ASK_CUR;
                    end else if (wall_ack) begin
                        wall_req_r <= 1'b0;
                        if (!wall_hit) begin
                            target_x_r <= wall_x_r;
                            target_y_r <= wall_y_r;
                            cur_dir_r  <= ask_dir_r;
                            state_r    <= ST_MOVE;
                        end else begin
                            state_r <= ST_ASK_CUR;
                        end
                    end
                end
                ST_ASK_CUR: begin
                    if (!wall_req_r) begin
                        if ((ask_dir_r == cur_dir_r) || cur_nb_s.oob) begin
                            state_r <= ST_IDLE;
                        end else begin
                            wall_req_r <= 1'b1;
                            wall_x_r   <= cur_nb_s.x;
                            wall_y_r   <= cur_nb_s.y;
                        end
                    end else if (wall_ack) begin
                        wall_req_r <= 1'b0;
                        if (!wall_hit) begin
                            target_x_r <= wall_x_r;
                            target_y_r <= wall_y_r;
                            state_r    <= ST_MOVE;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_MOVE: begin
                    pos_x_r  <= target_x_r;
                    pos_y_r  <= target_y_r;
                    facing_r <= cur_dir_r;
                    moved_r  <= 1'b1;
                    state_r  <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign wall_req = wall_req_r;
    assign wall_x   = wall_x_r;
    assign wall_y   = wall_y_r;
    assign pos_x    = pos_x_r;
    assign pos_y    = pos_y_r;
    assign facing   = facing_r;
    assign moved    = moved_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_pacman_mover.sv
// Scoreboard bench for pacman_mover: expected moves are queued as stimulus is
// driven and popped whenever the DUT pulses moved.
module tb_pacman_mover;

    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] dir_req = 4'd0;
    logic       wall_ack = 1'b0;
    logic       wall_hit = 1'b0;
    logic       wall_req, moved, overrun;
    logic [4:0] wall_x, wall_y, pos_x, pos_y;
    logic [1:0] facing;

    pacman_mover #(.GRID_W(28), .GRID_H(31), .TICK_DIV(TD), .START_X(13), .START_Y(23)) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .dir_req(dir_req),
        .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
        .wall_ack(wall_ack), .wall_hit(wall_hit),
        .pos_x(pos_x), .pos_y(pos_y), .facing(facing),
        .moved(moved), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    typedef struct packed {logic [4:0] x; logic [4:0] y; logic [1:0] f;} exp_t;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [9:0] req_log[$];
    bit         wall_map [0:31][0:31];
    int         ack_delay = 1;
    int         req_cnt = 0;
    bit         ack_force = 1'b0;
    int         moves_seen = 0;
    logic       prev_moved = 1'b0;

    // Maze lookup model: acks after ack_delay request cycles.
    always @(negedge clock) begin
        if (ack_force) begin
            wall_ack = 1'b1;
            wall_hit = 1'b0;
            req_cnt  = 0;
        end else if (wall_req === 1'b1) begin
            req_cnt++;
            if (req_cnt == 1) req_log.push_back({wall_x, wall_y});
            if (req_cnt >= ack_delay) begin
                wall_ack = 1'b1;
                wall_hit = wall_map[wall_x][wall_y];
            end else begin
                wall_ack = 1'b0;
                wall_hit = 1'b0;
            end
        end else begin
            req_cnt  = 0;
            wall_ack = 1'b0;
            wall_hit = 1'b0;
        end
    end

    // Scoreboard: every moved pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (resetn && moved === 1'b1) begin
            moves_seen++;
            total++;
            if (prev_moved === 1'b1) begin
                bad++;
                $display("FAIL moved_width: got two consecutive high cycles, want one");
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_move: got (%0d,%0d,f%0d) want no move", pos_x, pos_y, facing);
            end else begin
                mon_e = exp_q.pop_front();
                if ({pos_x, pos_y, facing} !== mon_e) begin
                    bad++;
                    $display("FAIL move_scoreboard: got (%0d,%0d,f%0d) want (%0d,%0d,f%0d)",
                             pos_x, pos_y, facing, mon_e.x, mon_e.y, mon_e.f);
                end
            end
        end
        prev_moved = moved;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_exp(input int x, input int y, input int f);
        exp_q.push_back({5'(x), 5'(y), 2'(f)});
    endtask

    task automatic set_dir(input logic [3:0] v);
        dir_req = v;
        cycles(2);
        dir_req = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        enable = 1'b0;
        dir_req = 4'd0;
        ack_delay = 1;
        ack_force = 1'b0;
        foreach (wall_map[i, j]) wall_map[i][j] = 1'b0;
        exp_q.delete();
        req_log.delete();
        cycles(3);
        resetn = 1'b1;
        cycles(1);
    endtask

    // Exactly one tick per step: TD enabled cycles, then pause for completion.
    task automatic step(input int n);
        repeat (n) begin
            enable = 1'b1;
            cycles(TD);
            enable = 1'b0;
            cycles(10);
        end
    endtask

    task automatic test_reset();
        int ms;
        do_reset();
        total++;
        if ({pos_x, pos_y, facing, moved, overrun, wall_req} !== {5'd13, 5'd23, 2'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got pos=(%0d,%0d) f=%0d mv=%b ov=%b rq=%b want (13,23) f=0 0 0 0",
                     pos_x, pos_y, facing, moved, overrun, wall_req);
        end
        total++;
        if ({wall_x, wall_y} !== 10'd0) begin
            bad++;
            $display("FAIL reset_wall_xy: got (%0d,%0d) want (0,0)", wall_x, wall_y);
        end
        ms = moves_seen;
        push_exp(12, 23, 0); push_exp(11, 23, 0); push_exp(10, 23, 0);
        enable = 1'b1;
        cycles(3 * TD);
        enable = 1'b0;
        cycles(10);
        total++;
        if (moves_seen - ms !== 3) begin
            bad++;
            $display("FAIL three_ticks_moves: got %0d moves want 3", moves_seen - ms);
        end
        total++;
        if ({pos_x, pos_y, overrun, exp_q.size() == 0} !== {5'd10, 5'd23, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL three_ticks_pos: got (%0d,%0d) ov=%b pending=%0d want (10,23) ov=0 pending=0",
                     pos_x, pos_y, overrun, exp_q.size());
        end
    endtask

    task automatic test_buffered_turn();
        do_reset();
        wall_map[12][22] = 1'b1;
        set_dir(4'b0010);
        push_exp(13, 22, 2);
        step(1);
        total++;
        if ({pos_x, pos_y, facing} !== {5'd13, 5'd22, 2'd2}) begin
            bad++;
            $display("FAIL turn_up: got (%0d,%0d,f%0d) want (13,22,f2)", pos_x, pos_y, facing);
        end
        do_reset();
        wall_map[13][22] = 1'b1;
        set_dir(4'b0010);
        push_exp(12, 23, 0);
        step(1);
        total++;
        if ({pos_x, pos_y, facing} !== {5'd12, 5'd23, 2'd0}) begin
            bad++;
            $display("FAIL turn_blocked_continue: got (%0d,%0d,f%0d) want (12,23,f0)", pos_x, pos_y, facing);
        end
        push_exp(12, 22, 2);
        step(1);
        total++;
        if ({pos_x, pos_y, facing, exp_q.size() == 0} !== {5'd12, 5'd22, 2'd2, 1'b1}) begin
            bad++;
            $display("FAIL turn_buffered_later: got (%0d,%0d,f%0d) pending=%0d want (12,22,f2) pending=0",
                     pos_x, pos_y, facing, exp_q.size());
        end
    endtask

    task automatic test_stop();
        int ms;
        do_reset();
        wall_map[12][23] = 1'b1;
        set_dir(4'b1000);
        ms = moves_seen;
        enable = 1'b1;
        cycles(5 * TD);
        enable = 1'b0;
        cycles(10);
        total++;
        if ({pos_x, pos_y, overrun} !== {5'd13, 5'd23, 1'b0} || moves_seen != ms) begin
            bad++;
            $display("FAIL stop_at_wall: got (%0d,%0d) ov=%b moves=%0d want (13,23) ov=0 moves=0",
                     pos_x, pos_y, overrun, moves_seen - ms);
        end
    endtask

    // Walks to row 14, through both tunnel mouths, then to (5,0) heading right.
    task automatic test_tunnel_and_boundary();
        do_reset();
        set_dir(4'b0010);
        for (int i = 1; i <= 9; i++) push_exp(13, 23 - i, 2);
        step(9);
        set_dir(4'b1000);
        for (int i = 1; i <= 13; i++) push_exp(13 - i, 14, 0);
        step(13);
        push_exp(27, 14, 0);
        step(1);
        total++;
        if ({pos_x, pos_y, facing} !== {5'd27, 5'd14, 2'd0}) begin
            bad++;
            $display("FAIL tunnel_left: got (%0d,%0d,f%0d) want (27,14,f0)", pos_x, pos_y, facing);
        end
        set_dir(4'b0100);
        push_exp(0, 14, 1);
        step(1);
        total++;
        if ({pos_x, pos_y, facing} !== {5'd0, 5'd14, 2'd1}) begin
            bad++;
            $display("FAIL tunnel_right: got (%0d,%0d,f%0d) want (0,14,f1)", pos_x, pos_y, facing);
        end
        set_dir(4'b0010);
        for (int i = 1; i <= 14; i++) push_exp(0, 14 - i, 2);
        step(14);
        set_dir(4'b0100);
        for (int i = 1; i <= 5; i++) push_exp(i, 0, 1);
        step(5);
        total++;
        if ({pos_x, pos_y} !== {5'd5, 5'd0}) begin
            bad++;
            $display("FAIL reach_top_row: got (%0d,%0d) want (5,0)", pos_x, pos_y);
        end
        set_dir(4'b0010);
        req_log.delete();
        push_exp(6, 0, 1);
        step(1);
        total++;
        if (req_log.size() != 1 || req_log[0] !== {5'd6, 5'd0}) begin
            bad++;
            $display("FAIL top_edge_requests: got %0d requests first=%h want 1 request at (6,0)",
                     req_log.size(), (req_log.size() > 0) ? req_log[0] : 10'h3ff);
        end
        total++;
        if ({pos_x, pos_y, facing, exp_q.size() == 0} !== {5'd6, 5'd0, 2'd1, 1'b1}) begin
            bad++;
            $display("FAIL top_edge_fallback: got (%0d,%0d,f%0d) pending=%0d want (6,0,f1) pending=0",
                     pos_x, pos_y, facing, exp_q.size());
        end
    endtask

    task automatic test_slow_ack();
        bit got_req = 1'b0, got_ovr = 1'b0, stable = 1'b1;
        logic [4:0] sx, sy;
        do_reset();
        ack_delay = 6;
        push_exp(12, 23, 0);
        enable = 1'b1;
        for (int n = 0; n < 20 && !got_req; n++) begin
            @(negedge clock);
            if (wall_req === 1'b1) got_req = 1'b1;
        end
        total++;
        if (!got_req) begin
            bad++;
            $display("FAIL slow_req_seen: got no wall_req within 20 cycles want one");
        end
        sx = wall_x;
        sy = wall_y;
        for (int n = 0; n < 30 && !got_ovr; n++) begin
            @(negedge clock);
            if (wall_req === 1'b1 && {wall_x, wall_y} !== {sx, sy}) stable = 1'b0;
            if (overrun === 1'b1) got_ovr = 1'b1;
        end
        enable = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clock);
            if (wall_req === 1'b1 && {wall_x, wall_y} !== {sx, sy}) stable = 1'b0;
        end
        total++;
        if (!got_ovr || !stable || {sx, sy} !== {5'd12, 5'd23}) begin
            bad++;
            $display("FAIL slow_ack_handshake: got ovr=%b stable=%b req=(%0d,%0d) want 1 1 (12,23)",
                     got_ovr, stable, sx, sy);
        end
        total++;
        if ({pos_x, pos_y, overrun, exp_q.size() == 0} !== {5'd12, 5'd23, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL slow_ack_move: got (%0d,%0d) ov=%b pending=%0d want (12,23) ov=1 pending=0",
                     pos_x, pos_y, overrun, exp_q.size());
        end
    endtask

    task automatic test_glitch_reset();
        bit got_req = 1'b0;
        int ms;
        do_reset();
        set_dir(4'b0010);
        dir_req = 4'b1100;
        cycles(3);
        dir_req = 4'd0;
        push_exp(13, 22, 2);
        step(1);
        total++;
        if ({pos_x, pos_y, facing} !== {5'd13, 5'd22, 2'd2}) begin
            bad++;
            $display("FAIL glitch_holds_want: got (%0d,%0d,f%0d) want (13,22,f2)", pos_x, pos_y, facing);
        end
        ack_delay = 6;
        enable = 1'b1;
        for (int n = 0; n < 20 && !got_req; n++) begin
            @(negedge clock);
            if (wall_req === 1'b1) got_req = 1'b1;
        end
        #1 resetn = 1'b0;
        #1;
        total++;
        if (!got_req || {wall_req, pos_x, pos_y, facing} !== {1'b0, 5'd13, 5'd23, 2'd0}) begin
            bad++;
            $display("FAIL reset_mid_handshake: got req_seen=%b rq=%b (%0d,%0d,f%0d) want 1 0 (13,23,f0)",
                     got_req, wall_req, pos_x, pos_y, facing);
        end
        enable = 1'b0;
        ack_delay = 1;
        exp_q.delete();
        cycles(2);
        resetn = 1'b1;
        ms = moves_seen;
        ack_force = 1'b1;
        cycles(3);
        ack_force = 1'b0;
        cycles(2);
        total++;
        if ({wall_req, pos_x, pos_y} !== {1'b0, 5'd13, 5'd23} || moves_seen != ms) begin
            bad++;
            $display("FAIL late_ack_ignored: got rq=%b (%0d,%0d) moves=%0d want 0 (13,23) 0",
                     wall_req, pos_x, pos_y, moves_seen - ms);
        end
        push_exp(12, 23, 0);
        step(1);
        total++;
        if ({pos_x, pos_y, exp_q.size() == 0} !== {5'd12, 5'd23, 1'b1}) begin
            bad++;
            $display("FAIL after_reset_move: got (%0d,%0d) pending=%0d want (12,23) pending=0",
                     pos_x, pos_y, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_buffered_turn();
        test_stop();
        test_tunnel_and_boundary();
        test_slow_ack();
        test_glitch_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1);
    end

endmodule
